mux_n_pipe: RTL

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/mux_n_pipe.sv
// N-way channel select feeding a two-entry (output + skid) registered pipe.
// in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           occupancy
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             skid_valid_q, skid_valid_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             in_xfer;
  logic             out_free;

  // Out-of-range selects match no channel and therefore yield all zeros.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_err  = 32'(in_sel) >= 32'(N);
  assign in_ready = !skid_valid_q;
  assign in_xfer  = in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_data_d  = sel_data;
        out_err_d   = sel_err;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // OUT is stalled and the skid is free: park the beat behind it.
      skid_data_d  = sel_data;
      skid_err_d   = sel_err;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule
